// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - request/response bundle between seq_divider and its peer ALU units
// signed_op exists only when SEQ_DIV_SIGNED_EN is defined
interface seq_divider_if #(
    parameter int WIDTH     = 64,
    parameter int NUM_PEERS = 3,
    parameter int SRC_W     = 2
);
    logic                 start;
    logic [SRC_W-1:0]     src;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [NUM_PEERS-1:0] peer_working;
    logic [NUM_PEERS-1:0] ack_in;
`ifdef SEQ_DIV_SIGNED_EN
    logic                 signed_op;
`endif
    logic                 ready;
    logic                 working;
    logic                 done;
    logic [NUM_PEERS-1:0] ack_out;
    logic [WIDTH-1:0]     result;
    logic [WIDTH-1:0]     remainder;
    logic                 div_by_zero;

    modport master (
`ifdef SEQ_DIV_SIGNED_EN
        output signed_op,
`endif
        output start, src, a, b, peer_working, ack_in,
        input  ready, working, done, ack_out, result, remainder, div_by_zero
    );

    modport slave (
`ifdef SEQ_DIV_SIGNED_EN
        input  signed_op,
`endif
        input  start, src, a, b, peer_working, ack_in,
        output ready, working, done, ack_out, result, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider with peer interlock and per-peer ack
// Optional two's-complement mode enabled by SEQ_DIV_SIGNED_EN
module seq_divider #(
    parameter int WIDTH     = 64,
    parameter int NUM_PEERS = 3,
    parameter int SRC_W     = 2
) (
    input logic          clk,
    input logic          rst,
    seq_divider_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [SRC_W-1:0]     src_q;
    // dvd_q holds the dividend magnitude; quotient bits shift in from the bottom during RUN
    logic [WIDTH-1:0]     dvd_q;
    logic [WIDTH-1:0]     dvs_q;
    logic [WIDTH:0]       rem_q;
    logic [WIDTH-1:0]     result_q;
    logic [WIDTH-1:0]     remainder_q;
    logic                 dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
    logic                 q_neg;
    logic                 r_neg;
`endif

    logic                 src_ok;
    logic [NUM_PEERS-1:0] ack_vec;
    logic [WIDTH+1:0]     diff;
    logic                 borrow;
    logic [WIDTH:0]       rem_nx;
    logic [WIDTH-1:0]     quo_nx;

    assign src_ok = (32'(bus.src) < 32'(NUM_PEERS));

    always_comb begin
        ack_vec = '0;
        if (state == S_DONE) begin
            ack_vec = NUM_PEERS'(1) << src_q;
        end
    end

    // One restoring step: shift rem:quot left, trial-subtract divisor, keep on no borrow
    always_comb begin
        diff   = {rem_q, dvd_q[WIDTH-1]} - {2'b00, dvs_q};
        borrow = diff[WIDTH+1];
        rem_nx = borrow ? {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]} : diff[WIDTH:0];
        quo_nx = {dvd_q[WIDTH-2:0], ~borrow};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            src_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start && src_ok) begin
                        src_q <= bus.src;
`ifdef SEQ_DIV_SIGNED_EN
                        if (bus.signed_op) begin
                            dvd_q <= bus.a[WIDTH-1] ? -bus.a : bus.a;
                            dvs_q <= bus.b[WIDTH-1] ? -bus.b : bus.b;
                            q_neg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                            r_neg <= bus.a[WIDTH-1];
                        end else begin
                            dvd_q <= bus.a;
                            dvs_q <= bus.b;
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                        end
`else
                        dvd_q <= bus.a;
                        dvs_q <= bus.b;
`endif
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!(|bus.peer_working)) begin
                        if (dvs_q == '0) begin
                            // Divide by zero: the raw dividend is reported back as remainder
                            dbz_q    <= 1'b1;
                            result_q <= '1;
`ifdef SEQ_DIV_SIGNED_EN
                            remainder_q <= r_neg ? -dvd_q : dvd_q;
`else
                            remainder_q <= dvd_q;
`endif
                            state <= S_DONE;
                        end else begin
                            rem_q <= '0;
                            cnt   <= CNT_W'(WIDTH - 1);
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    dvd_q <= quo_nx;
                    rem_q <= rem_nx;
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        dbz_q <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
                        // Truncating division: quotient sign from a^b, remainder sign from a
                        result_q    <= q_neg ? -quo_nx : quo_nx;
                        remainder_q <= r_neg ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
`else
                        result_q    <= quo_nx;
                        remainder_q <= rem_nx[WIDTH-1:0];
`endif
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (|(bus.ack_in & ack_vec)) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready       = (state == S_IDLE);
    assign bus.working     = (state == S_RUN);
    assign bus.done        = (state == S_DONE);
    assign bus.ack_out     = ack_vec;
    assign bus.result      = result_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider against an arithmetic reference model
// Signed scenarios compile in when SEQ_DIV_SIGNED_EN is defined
module tb_seq_divider;
    localparam int W = 64;
    localparam int P = 3;
    localparam int S = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seq_divider_if #(.WIDTH(W), .NUM_PEERS(P), .SRC_W(S)) bus ();

    seq_divider #(.WIDTH(W), .NUM_PEERS(P), .SRC_W(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                    output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        z = (b == '0);
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
                q = a;
                r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Drives one request, returns the cycle (1 = first cycle after accept) in which done appeared
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [S-1:0] src,
                            input logic sgn, input int busy, input logic [P-1:0] busy_pat,
                            input bit toggle, input int poke_k, output int done_k, output int run_k);
        @(negedge clk);
        bus.start = 1'b1;
        bus.src   = src;
        bus.a     = a;
        bus.b     = b;
`ifdef SEQ_DIV_SIGNED_EN
        bus.signed_op = sgn;
`else
        if (sgn) bus.a = a;
`endif
        bus.peer_working = (busy > 0) ? busy_pat : '0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = {$urandom(), $urandom()};
        bus.b     = {$urandom(), $urandom()};
        done_k = -1;
        run_k  = -1;
        for (int k = 1; k <= 300; k++) begin
            if (run_k < 0 && bus.working) run_k = k;
            if (bus.done) begin
                done_k = k;
                break;
            end
            if (bus.working && toggle) bus.peer_working = P'($urandom());
            else if (k <= busy)        bus.peer_working = busy_pat;
            else                       bus.peer_working = '0;
            bus.start = (k == poke_k);
            if (k == poke_k) begin
                bus.src = S'($urandom());
                bus.a   = {$urandom(), $urandom()};
                bus.b   = {$urandom(), $urandom()};
            end
            @(posedge clk);
            #1;
        end
        bus.start        = 1'b0;
        bus.peer_working = '0;
    endtask

    task automatic give_ack(input logic [P-1:0] mask);
        bus.ack_in = mask;
        @(posedge clk);
        #1;
        bus.ack_in = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
        checks++; if (bus.working !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_status: working=%b done=%b expected 0 0", bus.working, bus.done); end
        checks++; if (bus.ack_out !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b expected 000", bus.ack_out); end
        checks++; if (bus.result !== '0 || bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_data: result=%h rem=%h dbz=%b expected zeros", bus.result, bus.remainder, bus.div_by_zero); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_release: ready=%b done=%b expected 1 0", bus.ready, bus.done); end
    endtask

    task automatic test_basic();
        int dk, rk;
        drive_op(64'd100, 64'd7, 2'd1, 1'b0, 0, 3'b000, 1'b0, 0, dk, rk);
        checks++; if (rk !== 2) begin errors++; $display("FAIL basic_run_start: got %0d expected 2", rk); end
        checks++; if (dk !== 66) begin errors++; $display("FAIL basic_latency: got %0d expected 66", dk); end
        checks++; if (bus.result !== 64'd14 || bus.remainder !== 64'd2) begin errors++; $display("FAIL basic_value: q=%0d r=%0d expected 14 2", bus.result, bus.remainder); end
        checks++; if (bus.ack_out !== 3'b010 || bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_ack: ack=%b dbz=%b expected 010 0", bus.ack_out, bus.div_by_zero); end
        give_ack(3'b101);
        checks++; if (bus.done !== 1'b1 || bus.ack_out !== 3'b010) begin errors++; $display("FAIL basic_foreign_ack: done=%b ack=%b expected 1 010", bus.done, bus.ack_out); end
        give_ack(3'b010);
        checks++; if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.ack_out !== 3'b000) begin errors++; $display("FAIL basic_release: ready=%b done=%b ack=%b expected 1 0 000", bus.ready, bus.done, bus.ack_out); end
        checks++; if (bus.result !== 64'd14 || bus.remainder !== 64'd2) begin errors++; $display("FAIL basic_hold: q=%0d r=%0d expected 14 2", bus.result, bus.remainder); end
    endtask

    task automatic test_div_zero();
        int dk, rk;
        drive_op(64'd5, 64'd0, 2'd0, 1'b0, 0, 3'b000, 1'b0, 0, dk, rk);
        checks++; if (dk !== 2) begin errors++; $display("FAIL dbz_latency: got %0d expected 2", dk); end
        checks++; if (bus.div_by_zero !== 1'b1 || bus.result !== 64'hFFFF_FFFF_FFFF_FFFF || bus.remainder !== 64'd5) begin errors++; $display("FAIL dbz_value: dbz=%b q=%h r=%h expected 1 ffffffffffffffff 5", bus.div_by_zero, bus.result, bus.remainder); end
        checks++; if (bus.ack_out !== 3'b001) begin errors++; $display("FAIL dbz_ack: got %b expected 001", bus.ack_out); end
        give_ack(3'b001);
    endtask

    task automatic test_interlock();
        int dk, rk;
        logic [W-1:0] a, b, q, r;
        logic z;
        a = {$urandom(), $urandom()};
        b = {32'd0, $urandom()} | 64'd1;
        ref_div(a, b, 1'b0, q, r, z);
        drive_op(a, b, 2'd2, 1'b0, 10, 3'b100, 1'b1, 0, dk, rk);
        checks++; if (rk !== 12) begin errors++; $display("FAIL interlock_run_start: got %0d expected 12", rk); end
        checks++; if (dk !== 12 + W) begin errors++; $display("FAIL interlock_latency: got %0d expected %0d", dk, 12 + W); end
        checks++; if (bus.result !== q || bus.remainder !== r) begin errors++; $display("FAIL interlock_value: q=%h r=%h expected %h %h", bus.result, bus.remainder, q, r); end
        give_ack(3'b100);
    endtask

    task automatic test_ignored_start();
        int dk, rk;
        bit seen;
        logic [W-1:0] q, r;
        logic z;
        ref_div(64'd1000, 64'd33, 1'b0, q, r, z);
        drive_op(64'd1000, 64'd33, 2'd0, 1'b0, 0, 3'b000, 1'b0, 20, dk, rk);
        checks++; if (dk !== 66 || bus.result !== q || bus.remainder !== r) begin errors++; $display("FAIL ignore_run: lat=%0d q=%0d r=%0d expected 66 %0d %0d", dk, bus.result, bus.remainder, q, r); end
        bus.start = 1'b1;
        bus.src   = 2'd2;
        bus.a     = 64'd77;
        bus.b     = 64'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++; if (bus.done !== 1'b1 || bus.ack_out !== 3'b001 || bus.result !== q) begin errors++; $display("FAIL ignore_done: done=%b ack=%b q=%0d expected 1 001 %0d", bus.done, bus.ack_out, bus.result, q); end
        give_ack(3'b001);
        seen = 1'b0;
        for (int i = 0; i < W + 6; i++) begin
            if (bus.done || bus.ack_out != 3'b000 || !bus.ready) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ignore_single_ack: extra activity=%b expected 0", seen); end
        @(negedge clk);
        bus.start = 1'b1;
        bus.src   = 2'd3;
        bus.a     = 64'd9;
        bus.b     = 64'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.ready !== 1'b1 || bus.working !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL ignore_bad_src: ready=%b working=%b done=%b expected 1 0 0", bus.ready, bus.working, bus.done); end
    endtask

    task automatic test_reset_mid_run();
        int dk, rk;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.src   = 2'd1;
        bus.a     = 64'd123456789;
        bus.b     = 64'd10;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        checks++; if (bus.working !== 1'b1) begin errors++; $display("FAIL midrst_running: got %b expected 1", bus.working); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.ready !== 1'b1 || bus.working !== 1'b0 || bus.done !== 1'b0 || bus.ack_out !== 3'b000) begin errors++; $display("FAIL midrst_status: ready=%b working=%b done=%b ack=%b expected 1 0 0 000", bus.ready, bus.working, bus.done, bus.ack_out); end
        checks++; if (bus.result !== '0 || bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL midrst_data: q=%h r=%h dbz=%b expected zeros", bus.result, bus.remainder, bus.div_by_zero); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.ack_out != 3'b000) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_ack: activity=%b expected 0", seen); end
        drive_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'd2, 1'b0, 0, 3'b000, 1'b0, 0, dk, rk);
        checks++; if (dk !== 66 || bus.result !== 64'hFFFF_FFFF_FFFF_FFFF || bus.remainder !== '0) begin errors++; $display("FAIL midrst_after: lat=%0d q=%h r=%h expected 66 ffffffffffffffff 0", dk, bus.result, bus.remainder); end
        give_ack(3'b100);
    endtask

    task automatic test_random_back_to_back();
        int dk, rk, busy, mode, exp_lat;
        logic [W-1:0] a, b, q, r;
        logic [S-1:0] src;
        logic [P-1:0] mask;
        logic z, sgn;
        for (int n = 0; n < 24; n++) begin
            mode = $urandom_range(0, 4);
            a    = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 500)) : {$urandom(), $urandom()};
            case (mode)
                0: b = {$urandom(), $urandom()};
                1: b = 64'($urandom_range(1, 1000));
                2: b = '0;
                3: b = {32'd0, $urandom()};
                default: b = a;
            endcase
            src  = S'($urandom_range(0, P - 1));
            busy = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
            mask = P'($urandom_range(1, 7));
`ifdef SEQ_DIV_SIGNED_EN
            sgn = 1'($urandom_range(0, 1));
`else
            sgn = 1'b0;
`endif
            ref_div(a, b, sgn, q, r, z);
            exp_lat = z ? busy + 2 : busy + 2 + W;
            drive_op(a, b, src, sgn, busy, mask, 1'b1, 0, dk, rk);
            checks++; if (dk !== exp_lat) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, dk, exp_lat); end
            checks++; if (bus.result !== q || bus.remainder !== r || bus.div_by_zero !== z) begin errors++; $display("FAIL rand_value[%0d]: a=%h b=%h s=%b q=%h r=%h z=%b expected %h %h %b", n, a, b, sgn, bus.result, bus.remainder, bus.div_by_zero, q, r, z); end
            checks++; if (bus.ack_out !== (P'(1) << src)) begin errors++; $display("FAIL rand_ack[%0d]: got %b expected %b", n, bus.ack_out, P'(1) << src); end
            give_ack(P'(1) << src);
        end
    endtask

`ifdef SEQ_DIV_SIGNED_EN
    task automatic test_signed();
        int dk, rk;
        drive_op(-64'sd7, 64'd2, 2'd0, 1'b1, 0, 3'b000, 1'b0, 0, dk, rk);
        checks++; if (bus.result !== -64'sd3 || bus.remainder !== -64'sd1) begin errors++; $display("FAIL signed_neg: q=%h r=%h expected fffffffffffffffd ffffffffffffffff", bus.result, bus.remainder); end
        give_ack(3'b001);
        drive_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 1'b1, 0, 3'b000, 1'b0, 0, dk, rk);
        checks++; if (bus.result !== 64'h8000_0000_0000_0000 || bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL signed_min: q=%h r=%h dbz=%b expected 8000000000000000 0 0", bus.result, bus.remainder, bus.div_by_zero); end
        give_ack(3'b010);
    endtask
`endif

    initial begin
        checks           = 0;
        errors           = 0;
        bus.start        = 1'b0;
        bus.src          = '0;
        bus.a            = '0;
        bus.b            = '0;
        bus.peer_working = '0;
        bus.ack_in       = '0;
`ifdef SEQ_DIV_SIGNED_EN
        bus.signed_op    = 1'b0;
`endif
        test_reset();
        test_basic();
        test_div_zero();
        test_interlock();
        test_ignored_start();
        test_reset_mid_run();
        test_random_back_to_back();
`ifdef SEQ_DIV_SIGNED_EN
        test_signed();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
